// File: rtl/bcd_serial_adder_ctrl_pkg.sv
// Shared constants and FSM state type for the serial packed-BCD adder.
package bcd_serial_adder_ctrl_pkg;

    localparam int unsigned BcdW    = 4;      // bits per BCD digit
    localparam logic [3:0]  BcdMax  = 4'd9;   // largest valid BCD digit
    localparam logic [4:0]  BcdCorr = 5'd6;   // decimal correction added when a digit overflows

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit decimal adder: binary add, then +6 correction when the result exceeds 9.
module bcd_digit_add
    import bcd_serial_adder_ctrl_pkg::*;
(
    input  logic [BcdW-1:0] da,
    input  logic [BcdW-1:0] db,
    input  logic            cin,
    output logic [BcdW-1:0] digit,
    output logic            cout,
    output logic            invalid
);

    logic [BcdW:0] t;
    logic [BcdW:0] t_corr;

    // Raw sum, corrected digit/carry, and invalid-digit flag.
    always_comb begin
        t       = {1'b0, da} + {1'b0, db} + {{BcdW{1'b0}}, cin};
        t_corr  = t + BcdCorr;
        digit   = t[BcdW-1:0];
        cout    = 1'b0;
        if (t > {1'b0, BcdMax}) begin
            digit = t_corr[BcdW-1:0];
            cout  = 1'b1;
        end
        // Out-of-range digits still go through the same rule; they are only flagged.
        invalid = (da > BcdMax) || (db > BcdMax);
    end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Multi-digit packed-BCD adder: one digit per clock, LSD first, start/busy/done handshake.
module bcd_serial_adder_ctrl
    import bcd_serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned CNT_W  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [BcdW*DIGITS-1:0] a,
    input  logic [BcdW*DIGITS-1:0] b,
    input  logic                   carry_in,
    output logic                   busy,
    output logic                   done,
    output logic [BcdW*DIGITS-1:0] sum,
    output logic                   carry,
    output logic                   err
);

    localparam int unsigned SumW = BcdW * DIGITS;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SumW-1:0]   a_sh_q, a_sh_d;
    logic [SumW-1:0]   b_sh_q, b_sh_d;
    logic [SumW-1:0]   sum_q, sum_d;
    logic              cy_q, cy_d;
    logic              carry_q, carry_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic [BcdW-1:0]   dig;
    logic              dig_cout;
    logic              dig_invalid;
    logic              last_digit;

    // Operand shift registers always present the current digit in their low nibble.
    bcd_digit_add u_digit_add (
        .da      (a_sh_q[BcdW-1:0]),
        .db      (b_sh_q[BcdW-1:0]),
        .cin     (cy_q),
        .digit   (dig),
        .cout    (dig_cout),
        .invalid (dig_invalid)
    );

    assign last_digit = (cnt_q == CNT_W'(DIGITS - 1));

    // Next-state logic for the FSM and the datapath registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cy_d    = cy_q;
        carry_d = carry_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    cy_d    = carry_in;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_sh_d = a_sh_q >> BcdW;
                b_sh_d = b_sh_q >> BcdW;
                // New digit enters from the top; after DIGITS shifts digit 0 sits at [3:0].
                sum_d  = SumW'({dig, sum_q} >> BcdW);
                cy_d   = dig_cout;
                cnt_d  = cnt_q + 1'b1;
                if (dig_invalid) begin
                    err_d = 1'b1;
                end
                if (last_digit) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    carry_d = dig_cout;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cy_q    <= 1'b0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cy_q    <= cy_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q == StRun);
    assign done  = done_q;
    assign sum   = sum_q;
    assign carry = carry_q;
    assign err   = err_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed self-checking bench for bcd_serial_adder_ctrl with DIGITS=4.
module tb_bcd_serial_adder_ctrl;

    localparam int unsigned DIGITS = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        carry_in;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        carry;
    logic        err;

    int n_cmp;
    int n_bad;

    bcd_serial_adder_ctrl #(
        .DIGITS (DIGITS),
        .CNT_W  (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .carry_in (carry_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carry    (carry),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and wait (bounded) for done; returns edges after start edge and busy samples.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                          output int lat, output int nbusy);
        a        = ta;
        b        = tb_v;
        carry_in = tc;
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        nbusy = 0;
        while (!done && lat < 20) begin
            if (busy) nbusy++;
            tick();
            lat++;
        end
    endtask

    int lat;
    int nbusy;
    int ndone;
    int first_done;
    int second_done;

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        carry_in = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();
        tick();

        // Reset then idle
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'h0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // 1234 + 5678
        run_op(16'h1234, 16'h5678, 1'b0, lat, nbusy);
        check("op1_latency", 32'(lat), 32'd4);
        check("op1_busy_cycles", 32'(nbusy), 32'd4);
        check("op1_done", 32'(done), 32'd1);
        check("op1_busy_at_done", 32'(busy), 32'd0);
        check("op1_sum", 32'(sum), 32'h6912);
        check("op1_carry", 32'(carry), 32'd0);
        check("op1_err", 32'(err), 32'd0);
        tick();
        check("op1_done_pulse", 32'(done), 32'd0);
        check("op1_sum_hold", 32'(sum), 32'h6912);

        // 9999 + 0001 ripples a carry through every digit
        run_op(16'h9999, 16'h0001, 1'b0, lat, nbusy);
        check("op2_sum", 32'(sum), 32'h0000);
        check("op2_carry", 32'(carry), 32'd1);

        // 9999 + 9999 + 1
        run_op(16'h9999, 16'h9999, 1'b1, lat, nbusy);
        check("op3_sum", 32'(sum), 32'h9999);
        check("op3_carry", 32'(carry), 32'd1);
        tick();

        // start held high: one done per DIGITS+1 cycles, busy restart in done cycle
        a           = 16'h1234;
        b           = 16'h5678;
        carry_in    = 1'b0;
        start       = 1'b1;
        tick();
        ndone       = 0;
        first_done  = -1;
        second_done = -1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = i;
                else if (second_done < 0) second_done = i;
                check("cont_sum", 32'(sum), 32'h6912);
            end
            if (i == 5) check("cont_restart_busy", 32'(busy), 32'd1);
        end
        start = 1'b0;
        check("cont_done_count", 32'(ndone), 32'd3);
        check("cont_first_done", 32'(first_done), 32'd4);
        check("cont_second_done", 32'(second_done), 32'd9);
        for (int i = 0; i < 6; i++) tick();

        // Operand change during RUN has no effect
        a        = 16'h0450;
        b        = 16'h0550;
        carry_in = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        a        = 16'h0000;
        b        = 16'h0000;
        carry_in = 1'b1;
        lat      = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        check("capt_latency", 32'(lat), 32'd4);
        check("capt_sum", 32'(sum), 32'h1000);
        check("capt_carry", 32'(carry), 32'd0);
        tick();

        // Invalid digit flagged and held
        run_op(16'h00A1, 16'h0001, 1'b0, lat, nbusy);
        check("inv_done", 32'(done), 32'd1);
        check("inv_err", 32'(err), 32'd1);
        check("inv_sum", 32'(sum), 32'h0102);
        tick();
        tick();
        check("inv_err_hold", 32'(err), 32'd1);
        check("inv_done_low", 32'(done), 32'd0);

        // Reset during RUN aborts immediately, no done afterwards
        a        = 16'h1234;
        b        = 16'h5678;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'h0);
        check("abort_carry", 32'(carry), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_serial_adder_ctrl.md
Name: bcd_serial_adder_ctrl

Overview:
Multi-digit packed-BCD adder that reuses one single-digit decimal adder, one digit per clock, least significant digit first.
- Sequences operand digits through the digit adder and ripples the decimal carry in a register between digits.
- Assembles the result and reports completion with a start/busy/done handshake.
- Sits between a control sequencer or register file and the arithmetic datapath wherever multi-digit BCD addition is needed.

Parameters:
DIGITS, 4, number of BCD digits per operand (≥1)
CNT_W, 3, digit counter width; must satisfy 2**CNT_W > DIGITS

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request a new addition; sampled only when idle
a  in  4*DIGITS  operand A, packed BCD, digit 0 = bits [3:0]
b  in  4*DIGITS  operand B, packed BCD
carry_in  in  1  decimal carry into digit 0
busy  out  1  high while digits are being processed
done  out  1  one-cycle pulse: sum/carry/err valid
sum  out  4*DIGITS  packed BCD result
carry  out  1  decimal carry out of the top digit
err  out  1  at least one operand digit was >9 in the last operation

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, busy=0, done=0, sum=0, carry=0, err=0, digit counter=0, internal carry=0.
- FSM states:
  - IDLE: if start=1 at an edge, latch a, b and carry_in into internal shift registers, clear err, set counter=0, go to RUN (busy=1 after that edge).
  - RUN: each cycle present latched digit[counter] of A and B plus the carry register to the digit adder.
    - At the edge, shift the 4-bit digit sum into the result register from the top, so after DIGITS shifts digit 0 sits at [3:0].
    - Load the digit carry into the carry register and increment the counter.
    - If either presented digit is >9, set err.
    - At the edge where counter==DIGITS-1: go to IDLE, busy=0, done=1 for exactly one cycle, carry output = final digit carry.
- Latency: start sampled at edge 0, so done is high during the cycle after edge DIGITS. Throughput is one operation per DIGITS+1 cycles.
- sum, carry and err hold their values after done until the next accepted start. The sum register is only updated during RUN, and intermediate values are not guaranteed valid while busy=1.
- start while busy=1 is ignored (no queueing). start in the done cycle is accepted, because the state is already IDLE.
- Operands are captured at start; changes to a, b or carry_in during RUN have no effect.
- Digit adder rule:
  - t = da + db + cin, as a 5-bit value.
  - If t > 9: digit = (t+6)[3:0] and cout = 1. Otherwise digit = t[3:0] and cout = 0.
- Invalid digits (>9) are computed by the same rule and flagged via err. No exception state.
- Reset mid-operation aborts immediately to reset values. No done pulse is produced for the aborted operation.
- DIGITS=1: RUN lasts one cycle, and done arrives one cycle after the start edge.

Decomposition:
- Shared package: BCD digit width constant (4), BCD max digit constant (9), correction constant (6), and the FSM state enum {IDLE, RUN}.
- One natural sub-module: bcd_digit_add. It is purely combinational: 4-bit da, db, 1-bit cin → 4-bit digit, 1-bit cout, 1-bit invalid.
- The controller instantiates one bcd_digit_add and contains the FSM, counter, operand shift registers and result register.

Test Plan:
- Reset then idle: rst_n low then high, no start → busy=0, done=0, sum=0, carry=0, err=0.
- DIGITS=4, a=0x1234, b=0x5678, carry_in=0, one-cycle start → busy for 4 cycles, done one cycle later, sum=0x6912, carry=0, err=0.
- a=0x9999, b=0x0001, carry_in=0 → sum=0x0000, carry=1. Then a=0x9999, b=0x9999, carry_in=1 → sum=0x9999, carry=1.
- Start asserted continuously from the first start through done: a second start during busy is ignored, and the start in the done cycle launches a new operation. Result is exactly one done per DIGITS+1 cycles.
- Change a and b to 0x0000 mid-RUN after a start with a=0x0450, b=0x0550 → sum=0x1000, carry=0 (captured operands used).
- a=0x00A1, b=0x0001 → err=1 at done and held. Separately, drop rst_n at cycle 2 of RUN → all outputs zero immediately, no done pulse follows.
